// File: rtl/rf_pkg.sv
// rf_pkg: register-file constants and types shared by the writeback scheduler
package rf_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int NUM_REGS = 32;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, searching upward from rr_ptr with wrap
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] g_idx;
    logic          found;
    int            idx;
    // grant is forced low during reset so the write port stays quiet
    always_comb begin
        gnt = '0;
        g_idx = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                g_idx = PW'(idx);
            end
        end
        if (!rst_n) begin
            gnt = '0;
            found = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (found) rr_ptr <= (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
    end
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: shares the register-file write port among writeback sources and stalls issue on RAW/WAW hazards
module rf_wb_sched import rf_pkg::*; #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            iss_valid,
    input  reg_addr_t                       iss_rd,
    input  reg_addr_t                       iss_rs1,
    input  reg_addr_t                       iss_rs2,
    output logic                            iss_stall,
    input  logic [NREQ-1:0]                 wb_valid,
    input  logic [NREQ-1:0][REG_AW-1:0]     wb_addr,
    input  logic [NREQ-1:0][XLEN-1:0]       wb_data,
    output logic [NREQ-1:0]                 wb_ready,
    output logic                            we3,
    output reg_addr_t                       wa3,
    output logic [XLEN-1:0]                 wd3,
    output logic [NUM_REGS-1:0]             busy,
    output logic                            err_spurious
);
    logic [NREQ-1:0]     gnt;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                issue;
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb_valid),
        .gnt   (gnt)
    );
    assign wb_ready = gnt;
    always_comb begin
        wa3 = '0;
        wd3 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wa3 = wb_addr[i];
                wd3 = wb_data[i];
            end
        end
        we3 = (|gnt) && (wa3 != '0);
    end
    // hazards use registered busy only; same-cycle writebacks release next cycle
    assign iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
    assign issue = iss_valid && !iss_stall && (iss_rd != '0);
    // set is applied after clear so a forced collision leaves the register busy
    always_comb begin
        busy_nxt = busy;
        if (we3) busy_nxt[wa3] = 1'b0;
        if (issue) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            err_spurious <= 1'b0;
        end else begin
            busy <= busy_nxt;
            err_spurious <= err_spurious | (we3 & ~busy[wa3]);
        end
    end
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed vector table, hand sequences and random traffic against a behavioural scoreboard model
module tb_rf_wb_sched;
    localparam int NREQ = 3;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              iss_valid;
    logic [4:0]        iss_rd, iss_rs1, iss_rs2;
    logic              iss_stall;
    logic [2:0]        wb_valid;
    logic [2:0][4:0]   wb_addr;
    logic [2:0][31:0]  wb_data;
    logic [2:0]        wb_ready;
    logic              we3;
    logic [4:0]        wa3;
    logic [31:0]       wd3;
    logic [31:0]       busy;
    logic              err_spurious;
    int checks = 0;
    int errors = 0;
    rf_wb_sched #(.NREQ(NREQ), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .busy(busy), .err_spurious(err_spurious)
    );
    always #5 clk = ~clk;
    // register file fed by the DUT write port, read back in directed checks
    logic [31:0] rf [32];
    always @(posedge clk) if (we3) rf[wa3] <= wd3;
    // behavioural model state
    bit [31:0] m_busy;
    bit [31:0] m_rf [32];
    int        m_ptr;
    bit        m_err;
    int        mg;
    bit        m_stall;
    int        wt [NREQ];
    typedef struct {
        logic iv; logic [4:0] rd, rs1, rs2; logic [2:0] wv;
        logic [4:0] a0, a1, a2; logic [31:0] d1;
        logic e_stall; logic [2:0] e_ready; logic e_we; logic [4:0] e_wa;
        logic [31:0] e_busy; logic e_err;
    } vec_t;
    vec_t tab [25];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input logic iv, input logic [4:0] rd, rs1, rs2, input logic [2:0] wv,
                                input logic [4:0] a0, a1, a2, input logic [31:0] d1,
                                input logic es, input logic [2:0] er, input logic ew,
                                input logic [4:0] ewa, input logic [31:0] eb, input logic ee);
        vec_t v;
        v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.wv = wv;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d1 = d1;
        v.e_stall = es; v.e_ready = er; v.e_we = ew; v.e_wa = ewa; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction
    function automatic int m_grant();
        int order[$];
        for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
        foreach (order[k]) if (wb_valid[order[k]]) return order[k];
        return -1;
    endfunction
    task automatic m_reset();
        m_busy = '0; m_ptr = 0; m_err = 1'b0;
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
    endtask
    task automatic drv(input logic iv, input logic [4:0] rd, rs1, rs2, input logic [2:0] wv,
                       input logic [4:0] a0, a1, a2, input logic [31:0] d1);
        iss_valid = iv; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2; wb_valid = wv;
        wb_addr[0] = a0; wb_addr[1] = a1; wb_addr[2] = a2;
        wb_data[0] = 32'h1000_0000 | 32'(a0); wb_data[1] = d1; wb_data[2] = 32'h2000_0000 | 32'(a2);
    endtask
    task automatic pre();
        logic [4:0]  ea;
        logic [31:0] ed;
        @(negedge clk);
        mg = m_grant();
        m_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
        ea = (mg >= 0) ? wb_addr[mg] : 5'd0;
        ed = (mg >= 0) ? wb_data[mg] : 32'd0;
        chk("stall", 64'(iss_stall), 64'(m_stall));
        chk("ready", 64'(wb_ready), (mg >= 0) ? 64'(1) << mg : 64'd0);
        chk("we3", 64'(we3), 64'(mg >= 0 && ea != 0));
        chk("wa3", 64'(wa3), 64'(ea));
        chk("wd3", 64'(wd3), 64'(ed));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("err", 64'(err_spurious), 64'(m_err));
        for (int i = 0; i < NREQ; i++) begin
            if (wb_ready[i]) begin
                chk("fair_wait", 64'(wt[i] < NREQ), 64'd1);
                wt[i] = 0;
            end else if (wb_valid[i]) wt[i]++;
        end
    endtask
    task automatic post();
        logic [4:0] a;
        @(posedge clk);
        if (mg >= 0) begin
            a = wb_addr[mg];
            if (a != 0) begin
                if (!m_busy[a]) m_err = 1'b1;
                m_busy[a] = 1'b0;
                m_rf[a] = wb_data[mg];
            end
            m_ptr = (mg + 1) % NREQ;
        end
        if (iss_valid && !m_stall && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        #1;
        if (mg >= 0) wb_valid[mg] = 1'b0;
    endtask
    initial begin
        tab[0]  = mk(1, 3, 1, 2, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h008, 0);
        tab[1]  = mk(1, 5, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h028, 0);
        tab[2]  = mk(1, 0, 5, 0, 3'b000, 0, 0, 0, 0,             1, 3'b000, 0, 0,  32'h028, 0);
        tab[3]  = mk(1, 0, 5, 0, 3'b010, 0, 5, 0, 32'hDEADBEEF,  1, 3'b010, 1, 5,  32'h008, 0);
        tab[4]  = mk(1, 0, 5, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h008, 0);
        tab[5]  = mk(0, 0, 0, 0, 3'b100, 0, 0, 3, 0,             0, 3'b100, 1, 3,  32'h000, 0);
        tab[6]  = mk(1, 6, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h040, 0);
        tab[7]  = mk(1, 7, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h0C0, 0);
        tab[8]  = mk(1, 8, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h1C0, 0);
        tab[9]  = mk(0, 0, 0, 0, 3'b111, 6, 7, 8, 32'h70,        0, 3'b001, 1, 6,  32'h180, 0);
        tab[10] = mk(0, 0, 0, 0, 3'b110, 6, 7, 8, 32'h70,        0, 3'b010, 1, 7,  32'h100, 0);
        tab[11] = mk(0, 0, 0, 0, 3'b100, 6, 7, 8, 32'h70,        0, 3'b100, 1, 8,  32'h000, 0);
        tab[12] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h000, 0);
        tab[13] = mk(1, 0, 0, 0, 3'b010, 0, 0, 0, 32'h1234,      0, 3'b010, 0, 0,  32'h000, 0);
        tab[14] = mk(1, 6, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h040, 0);
        tab[15] = mk(1, 7, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h0C0, 0);
        tab[16] = mk(1, 8, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h1C0, 0);
        tab[17] = mk(0, 0, 0, 0, 3'b111, 6, 7, 8, 32'h70,        0, 3'b100, 1, 8,  32'h0C0, 0);
        tab[18] = mk(0, 0, 0, 0, 3'b011, 6, 7, 8, 32'h70,        0, 3'b001, 1, 6,  32'h080, 0);
        tab[19] = mk(0, 0, 0, 0, 3'b010, 6, 7, 8, 32'h70,        0, 3'b010, 1, 7,  32'h000, 0);
        tab[20] = mk(0, 0, 0, 0, 3'b001, 9, 0, 0, 0,             0, 3'b001, 1, 9,  32'h000, 1);
        tab[21] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h000, 1);
        tab[22] = mk(1, 4, 0, 0, 3'b000, 0, 0, 0, 0,             0, 3'b000, 0, 0,  32'h010, 1);
        tab[23] = mk(1, 4, 0, 0, 3'b000, 0, 0, 0, 0,             1, 3'b000, 0, 0,  32'h010, 1);
        tab[24] = mk(1, 10, 0, 0, 3'b010, 0, 10, 0, 32'hA,       0, 3'b010, 1, 10, 32'h410, 1);
        // reset with traffic presented: outputs must stay quiet
        rst_n = 1'b0;
        drv(1, 3, 1, 2, 3'b111, 1, 2, 3, 32'h55);
        m_reset();
        #1;
        chk("rst_ready", 64'(wb_ready), 64'd0);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(iss_stall), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        drv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        rst_n = 1'b1;
        // directed vector table
        foreach (tab[k]) begin
            drv(tab[k].iv, tab[k].rd, tab[k].rs1, tab[k].rs2, tab[k].wv,
                tab[k].a0, tab[k].a1, tab[k].a2, tab[k].d1);
            pre();
            chk($sformatf("tab%0d_stall", k), 64'(iss_stall), 64'(tab[k].e_stall));
            chk($sformatf("tab%0d_ready", k), 64'(wb_ready), 64'(tab[k].e_ready));
            chk($sformatf("tab%0d_we3", k), 64'(we3), 64'(tab[k].e_we));
            chk($sformatf("tab%0d_wa3", k), 64'(wa3), 64'(tab[k].e_wa));
            post();
            chk($sformatf("tab%0d_busy", k), 64'(busy), 64'(tab[k].e_busy));
            chk($sformatf("tab%0d_err", k), 64'(err_spurious), 64'(tab[k].e_err));
        end
        chk("rf_x5", 64'(rf[5]), 64'h0000_0000_DEAD_BEEF);
        chk("rf_x10", 64'(rf[10]), 64'(m_rf[10]));
        // reset mid-operation: busy=0xF0, rr_ptr=1, two requests pending
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("err_cleared", 64'(err_spurious), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 4; r < 8; r++) begin
            drv(1, 5'(r), 0, 0, 3'b000, 0, 0, 0, 0);
            pre();
            post();
        end
        drv(0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        pre();
        post();
        chk("mid_busy_pre", 64'(busy), 64'h0F0);
        drv(1, 0, 4, 0, 3'b011, 4, 5, 0, 32'h5555);
        pre();
        chk("mid_ptr1_grant", 64'(wb_ready), 64'b010);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_we3", 64'(we3), 64'd0);
        chk("mid_ready", 64'(wb_ready), 64'd0);
        chk("mid_stall", 64'(iss_stall), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pre();
        chk("post_rst_grant0", 64'(wb_ready), 64'b001);
        post();
        // random traffic obeying the hold-until-ready protocol
        drv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!wb_valid[i] && $urandom_range(0, 2) == 0) begin
                    int cand[$];
                    for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
                    wb_valid[i] = 1'b1;
                    wb_addr[i] = (cand.size() > 0 && $urandom_range(0, 4) != 0)
                                 ? 5'(cand[$urandom_range(0, cand.size() - 1)]) : 5'($urandom_range(0, 31));
                    wb_data[i] = $urandom;
                end
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = 5'($urandom_range(0, 15));
            iss_rs1 = 5'($urandom_range(0, 15));
            iss_rs2 = 5'($urandom_range(0, 15));
            pre();
            post();
        end
        for (int r = 1; r < 32; r++) if (m_rf[r] !== 32'd0 || rf[r] !== 32'bx) chk($sformatf("rf_x%0d", r), 64'(rf[r]), 64'(m_rf[r]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file, which has one write port and two read ports. It shares the single write port (`we3`/`wa3`/`wd3`) among several writeback sources (ALU, load unit, multi-cycle mul/div) using round-robin arbitration. It also tracks which destination registers have a result in flight, and stalls issue on RAW and WAW hazards. It sits between the decode/issue stage and the register file.

## Interface
- `NREQ`, 3: number of writeback requesters; index 0 is the ALU.
- `XLEN`, 32: data width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: issue stage presents an instruction.
- `iss_rd` in 5: destination register; 0 means no writeback.
- `iss_rs1`, `iss_rs2` in 5 each: source registers; 0 is never a hazard.
- `iss_stall` out 1: instruction must not issue this cycle.
- `wb_valid` in NREQ: requester i has a result.
- `wb_addr` in NREQ×5: destination register per requester.
- `wb_data` in NREQ×XLEN: result data per requester.
- `wb_ready` out NREQ: one-hot grant; requester i's result is consumed at this edge.
- `we3` out 1, `wa3` out 5, `wd3` out XLEN: register-file write port.
- `busy` out 32: scoreboard bits; bit 0 is always 0.
- `err_spurious` out 1: sticky flag; a writeback targeted a non-busy nonzero register.

## Operation
**Scoreboard**
- `iss_stall` = `iss_valid` & (`busy[iss_rs1]` | `busy[iss_rs2]` | `busy[iss_rd]`).
- The stall uses registered `busy` only. A writeback granted in the same cycle does not clear the hazard until the next cycle.
- An instruction issues when `iss_valid` & !`iss_stall`. If it also has `iss_rd`≠0, `busy[iss_rd]` is set at that edge.

**Arbitration**
- Round-robin pointer `rr_ptr` (0..NREQ-1).
- The grant goes to the first asserted `wb_valid` found searching from `rr_ptr` upward, with wrap-around.
- After a grant to index g: `rr_ptr` ← (g+1) mod NREQ. With no grant, `rr_ptr` holds.
- At most one `wb_ready` bit is high. `wb_ready` = 0 whenever `wb_valid` = 0.
- Requesters hold `valid`, `addr` and `data` stable until they see `ready`. Dropping `valid` before `ready` is a protocol violation; behaviour is not defined.

**Write port**
- On a grant: `wa3`/`wd3` = the granted requester's `addr`/`data`, and `we3` = (`addr` ≠ 0).
- A grant to address 0 is consumed with `we3`=0.
- Otherwise `we3`=0, `wa3`=0, `wd3`=0.
- A grant with `addr`≠0 clears `busy[addr]` at the edge.
- If a granted `addr`≠0 has `busy[addr]`=0, `err_spurious` is set. The write still occurs.

**Set/clear on the same register in the same cycle**
- This cannot happen through legal issue, because WAW stalls the issuing instruction.
- If it is forced, set wins.

## Timing
- Grant is combinational: from `wb_valid` to `wb_ready`/`we3`/`wa3`/`wd3`, zero cycles.
- Data is in the register file after the granted edge. A read of that register in the following cycle returns the new value.
- `busy` clears at the same edge. A dependent instruction stalled in cycle N issues in cycle N+1 and reads the correct value.
- Each requester is guaranteed a grant within NREQ cycles of asserting `valid`.
- Reset (asynchronous, at any time, including mid-arbitration) forces:
  - `busy`=0, `rr_ptr`=0, `err_spurious`=0;
  - which makes `iss_stall`=0;
  - and, because combinational outputs follow their inputs, `wb_ready`=0, `we3`=0, `wa3`=0, `wd3`=0 while `rst_n`=0.
- After reset deasserts, the first edge behaves as in normal operation.

## Structure
- Package `rf_pkg`:
  - constants `XLEN`=32, `REG_AW`=5, `NUM_REGS`=32;
  - typedefs `reg_addr_t` (logic [4:0]) and `xlen_t` (logic [31:0]).
- Sub-module `rr_arbiter` (parameter `N`):
  - ports: `clk`, `rst_n`, `req[N]`, `gnt[N]`;
  - owns `rr_ptr`; one-hot, combinational grant.
- The top level holds the scoreboard register, the hazard compare, the write-port mux and the error flag.

## Test plan
- **Reset and idle.** Reset, then `iss_valid`=1 with rs1=1, rs2=2, rd=3 → `iss_stall`=0. Next cycle `busy`=0x0000_0008.
- **RAW stall and release.** Issue rd=5. Then hold rs1=5 → `iss_stall`=1. Requester 1 writes addr=5, data=0xDEAD_BEEF → `we3`=1, `wa3`=5, `wd3`=0xDEAD_BEEF in that cycle. `iss_stall`=0 the next cycle, and a read of x5 returns 0xDEAD_BEEF.
- **Round-robin fairness.** All three `wb_valid` held high with addrs 6, 7, 8 (busy pre-set) → grants in order 0, 1, 2, then `wb_valid`=0. Repeat with `rr_ptr`=2 → order 2, 0, 1.
- **x0 handling.** Issue rd=0 → `busy` unchanged. Writeback to addr 0 → `wb_ready`=1, `we3`=0, and `err_spurious` stays 0.
- **Spurious write.** Writeback to addr 9 with `busy[9]`=0 → `we3`=1 and `err_spurious`=1, which stays set until reset.
- **Reset mid-operation.** `busy`=0x0000_00F0, `rr_ptr`=1, two requests pending; assert `rst_n`=0 between edges → immediately `busy`=0, `we3`=0, `wb_ready`=0. After release, the first grant goes to requester 0.
